gf2m_digit_serial_mult: RTL and testbench

GF2M_DIGIT_SERIAL_MULT -- requirements
Module: gf2m_digit_serial_mult

---
 rtl/gf2m_digit_serial_mult.sv | 124 ++++++++++++
 tb/tb_gf2m_digit_serial_mult.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gf2m_digit_serial_mult.sv
// Digit-serial GF(2^M) polynomial-basis multiplier, D multiplier bits per cycle, MSD first.
// Result valid N=ceil(M/D) cycles after the accept edge; held in DONE until out_ready, one op in flight.
module gf2m_digit_serial_mult #(
  parameter int M = 163,
  parameter int D = 8,
  parameter logic [M-1:0] POLY = 163'hC9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] o,
  output logic         busy
);

  localparam int N   = (M + D - 1) / D;
  localparam int NDW = N * D;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic            rst_done;
  logic [M-1:0]    a_q;
  logic [NDW-1:0]  b_sh;
  logic [M-1:0]    acc;
  logic [M-1:0]    acc_next;
  logic [CW-1:0]   cnt;
  logic [M-1:0]    o_q;
  logic [D-1:0]    digit;

  // One reduction fold: multiply by x and replace x^M with POLY; valid for any POLY.
  function automatic logic [M-1:0] mulx(input logic [M-1:0] v);
    logic [M-1:0] s;
    s = v << 1;
    return s ^ (v[M-1] ? POLY : '0);
  endfunction

  assign digit = b_sh[NDW-1 -: D];

  always_comb begin
    logic [M-1:0] shifted;
    logic [M-1:0] apow;
    logic [M-1:0] prod;
    shifted = acc;
    apow    = a_q;
    prod    = '0;
    for (int j = 0; j < D; j++) begin
      shifted = mulx(shifted);
      if (digit[j]) prod = prod ^ apow;
      apow = mulx(apow);
    end
    acc_next = shifted ^ prod;
  end

  // in_ready stays low during reset and rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_done <= 1'b0;
    else     rst_done <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_done;
        if (in_valid && rst_done) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
      o_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q  <= a;
            b_sh <= NDW'(b);
            acc  <= '0;
            cnt  <= CW'(N - 1);
          end
        end
        RUN: begin
          acc  <= acc_next;
          b_sh <= b_sh << D;
          if (cnt == '0) o_q <= acc_next;
          else           cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o = o_q;

endmodule

// File: tb/tb_gf2m_digit_serial_mult.sv
// Bench for gf2m_digit_serial_mult: directed table, corner sequences, and random
// scoreboarded traffic against an independent schoolbook-multiply-then-reduce model.
module tb_gf2m_digit_serial_mult;

  localparam int M  = 163;
  localparam logic [M-1:0] POLY = 163'hC9;
  localparam int NR = 250;

  logic         clk = 1'b0;
  logic         rst;
  logic [M-1:0] a_in, b_in;
  logic [2:0]   iv, ordy;
  logic [2:0]   ir, ov, bsy;
  logic [M-1:0] o0, o1, o2;

  always #5 clk = ~clk;

  gf2m_digit_serial_mult #(.M(M), .D(1), .POLY(POLY)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_in), .b(b_in),
    .out_valid(ov[0]), .out_ready(ordy[0]), .o(o0), .busy(bsy[0]));
  gf2m_digit_serial_mult #(.M(M), .D(8), .POLY(POLY)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_in), .b(b_in),
    .out_valid(ov[1]), .out_ready(ordy[1]), .o(o1), .busy(bsy[1]));
  gf2m_digit_serial_mult #(.M(M), .D(163), .POLY(POLY)) u_d163 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_in), .b(b_in),
    .out_valid(ov[2]), .out_ready(ordy[2]), .o(o2), .busy(bsy[2]));

  typedef struct {
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [M-1:0] exp;
    string        nm;
  } vec_t;

  int           checks = 0;
  int           failures = 0;
  vec_t         tbl[7];
  logic [M-1:0] sbq[$];
  logic [M-1:0] pa[NR];
  logic [M-1:0] pb[NR];
  logic [M-1:0] res[3][NR];

  function automatic logic [M-1:0] gmul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [2*M-1:0] p;
    p = '0;
    for (int i = 0; i < M; i++)
      if (y[i]) p = p ^ ({{M{1'b0}}, x} << i);
    for (int i = 2*M-2; i >= M; i--)
      if (p[i]) begin
        p[i] = 1'b0;
        p = p ^ ({{M{1'b0}}, POLY} << (i - M));
      end
    return p[M-1:0];
  endfunction

  function automatic logic [M-1:0] rnd();
    logic [191:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return w[M-1:0];
  endfunction

  function automatic logic [M-1:0] lane_o(input int l);
    case (l)
      0:       return o0;
      1:       return o1;
      default: return o2;
    endcase
  endfunction

  function automatic int lane_d(input int l);
    case (l)
      0:       return 1;
      1:       return 8;
      default: return 163;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [M-1:0] act, input logic [M-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge with the lane idle; returns at the negedge after the output handshake.
  task automatic do_op(input int l, input logic [M-1:0] x, input logic [M-1:0] y,
                       input logic [M-1:0] exp, input string nm);
    int g;
    int lat;
    logic [M-1:0] e;
    a_in = x; b_in = y; iv[l] = 1'b1; g = 0;
    while (!ir[l] && g < 400) begin @(negedge clk); g++; end
    chki({nm, "_accept"}, int'(ir[l]), 1);
    sbq.push_back(exp);
    @(negedge clk);
    iv[l] = 1'b0; lat = 0;
    while (!ov[l] && lat < 400) begin @(negedge clk); lat++; end
    if (l == 1) chki({nm, "_latency"}, lat, 21);
    if (ov[l] && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({nm, "_o"}, lane_o(l), e);
    end else begin
      chki({nm, "_out_valid"}, int'(ov[l]), 1);
    end
    @(negedge clk);
  endtask

  task automatic run_lane(input int l);
    int issued;
    int recv;
    int cyc;
    bit pend;
    logic [M-1:0] e;
    string nm;
    nm = $sformatf("rand_d%0d", lane_d(l));
    issued = 0; recv = 0; cyc = 0; pend = 0;
    sbq.delete();
    while (recv < NR && cyc < NR * 300) begin
      if (pend) begin iv[l] = 1'b0; pend = 0; end
      if (!iv[l] && issued < NR && $urandom_range(0, 3) != 0) begin
        a_in = pa[issued]; b_in = pb[issued]; iv[l] = 1'b1;
      end
      ordy[l] = ($urandom_range(0, 3) != 0);
      if (iv[l] && ir[l]) begin
        sbq.push_back(gmul(pa[issued], pb[issued]));
        issued++;
        pend = 1;
      end
      if (ov[l] && ordy[l]) begin
        if (sbq.size() == 0) begin
          chki({nm, "_spurious_out"}, 1, 0);
        end else begin
          e = sbq.pop_front();
          chk(nm, lane_o(l), e);
          res[l][recv] = lane_o(l);
        end
        recv++;
      end
      @(negedge clk);
      cyc++;
    end
    chki({nm, "_count"}, recv, NR);
    iv[l] = 1'b0; ordy[l] = 1'b1;
  endtask

  initial begin
    logic [M-1:0] x162, ea, eb, ex, e;
    int g, cnt;

    rst = 1'b1; iv = '0; ordy = '1; a_in = '0; b_in = '0;
    x162 = '0; x162[162] = 1'b1;
    for (int i = 0; i < NR; i++) begin pa[i] = rnd(); pb[i] = rnd(); end
    for (int l = 0; l < 3; l++)
      for (int i = 0; i < NR; i++) res[l][i] = '0;

    tbl[0] = '{a: M'(1),  b: M'(1),   exp: M'(1),            nm: "one_x_one"};
    tbl[1] = '{a: M'(0),  b: rnd(),   exp: M'(0),            nm: "zero_x_b"};
    tbl[2] = '{a: x162,   b: M'(2),   exp: M'(8'hC9),        nm: "x162_x_x"};
    tbl[3] = '{a: x162,   b: x162,    exp: gmul(x162, x162), nm: "x162_sq"};
    tbl[4] = '{a: pa[0],  b: M'(1),   exp: pa[0],            nm: "a_x_one"};
    tbl[5] = '{a: M'(3),  b: M'(5),   exp: M'(15),           nm: "3_x_5"};
    tbl[6] = '{a: pa[1],  b: pb[1],   exp: gmul(pa[1], pb[1]), nm: "rand_pair"};

    @(negedge clk);
    chki("in_reset_in_ready", int'(ir), 0);
    chki("in_reset_busy", int'(bsy), 0);
    chki("in_reset_out_valid", int'(ov), 0);
    chk("in_reset_o", o1, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chki("post_reset_in_ready", int'(ir), 7);
    chki("post_reset_out_valid", int'(ov), 0);
    chki("post_reset_busy", int'(bsy), 0);
    chk("post_reset_o", o1, '0);

    for (int i = 0; i < 7; i++)
      do_op(1, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].nm);

    // Backpressure in DONE with in_valid pulsing and operands churning throughout.
    ea = rnd(); eb = rnd(); ex = gmul(ea, eb);
    ordy[1] = 1'b0; a_in = ea; b_in = eb; iv[1] = 1'b1;
    chki("bp_accept", int'(ir[1]), 1);
    sbq.push_back(ex);
    @(negedge clk);
    iv[1] = 1'b0; g = 0;
    while (!ov[1] && g < 400) begin
      a_in = rnd(); b_in = rnd(); iv[1] = 1'($urandom_range(0, 1));
      @(negedge clk); g++;
    end
    chki("bp_reach_done", int'(ov[1]), 1);
    for (int k = 0; k < 10; k++) begin
      iv[1] = k[0]; a_in = rnd(); b_in = rnd();
      chki("bp_out_valid_held", int'(ov[1]), 1);
      chki("bp_in_ready_low", int'(ir[1]), 0);
      chk("bp_o_held", o1, ex);
      @(negedge clk);
    end
    iv[1] = 1'b0; ordy[1] = 1'b1;
    if (sbq.size() > 0) begin e = sbq.pop_front(); chk("bp_handshake_o", o1, e); end
    @(negedge clk);
    chki("bp_no_capture_busy", int'(bsy[1]), 0);
    chki("bp_idle_out_valid", int'(ov[1]), 0);
    chk("bp_o_kept_idle", o1, ex);

    // Reset in the middle of a run aborts it.
    a_in = rnd(); b_in = rnd(); iv[1] = 1'b1;
    chki("rst_run_accept", int'(ir[1]), 1);
    @(negedge clk);
    iv[1] = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chki("rst_run_in_ready", int'(ir[1]), 0);
    chki("rst_run_busy", int'(bsy[1]), 0);
    chki("rst_run_out_valid", int'(ov[1]), 0);
    chk("rst_run_o", o1, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chki("rst_run_ready_back", int'(ir[1]), 1);
    cnt = 0;
    repeat (30) begin
      if (ov[1]) cnt++;
      @(negedge clk);
    end
    chki("rst_run_no_out_valid", cnt, 0);
    do_op(1, M'(3), M'(5), M'(15), "after_rst_3x5");

    run_lane(1);
    run_lane(2);
    run_lane(0);
    for (int i = 0; i < NR; i++) begin
      chk("cross_d1_vs_d163", res[0][i], res[2][i]);
      chk("cross_d8_vs_d163", res[1][i], res[2][i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
